// File: rtl/io_port_bridge.sv
// ============================================================================
// Module   : io_port_bridge
// Brief    : Processor I/O bridge with an input FIFO, a registered output port,
//            a data-available interrupt and a sticky overflow flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module io_port_bridge #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ext_in_data,
    input  logic              ext_in_valid,
    output logic              ext_in_ready,
    input  logic              in_rd,
    output logic [DATA_W-1:0] inputPort,
    output logic              in_empty,
    input  logic              out_wr,
    input  logic [DATA_W-1:0] out_wdata,
    output logic [DATA_W-1:0] outputPort,
    output logic              out_valid,
    input  logic              irq_en,
    output logic              interrupt,
    input  logic              clr_ovf,
    output logic              overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_irq;
    logic              r_ovf;

    logic              w_ready;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    // Flags come only from registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign w_ready = (r_count != c_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = ext_in_valid & w_ready;
    assign w_pop   = in_rd & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ext_in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            // Pulse only on the empty to non-empty transition.
            r_irq <= irq_en & w_push & w_empty;
            if (clr_ovf) begin
                r_ovf <= 1'b0;
            end else if (ext_in_valid && !w_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= out_wr;
            if (out_wr) begin
                r_out_data <= out_wdata;
            end
        end
    end

    assign ext_in_ready = w_ready;
    assign in_empty     = w_empty;
    assign inputPort    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign outputPort   = r_out_data;
    assign out_valid    = r_out_valid;
    assign interrupt    = r_irq;
    assign overflow     = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_io_port_bridge.sv
// ============================================================================
// Module   : tb_io_port_bridge
// Brief    : Directed self-checking bench for io_port_bridge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_io_port_bridge;

    logic        clk;
    logic        rst;
    logic [15:0] ext_in_data;
    logic        ext_in_valid;
    logic        ext_in_ready;
    logic        in_rd;
    logic [15:0] inputPort;
    logic        in_empty;
    logic        out_wr;
    logic [15:0] out_wdata;
    logic [15:0] outputPort;
    logic        out_valid;
    logic        irq_en;
    logic        interrupt;
    logic        clr_ovf;
    logic        overflow;

    int total;
    int bad;

    io_port_bridge #(.DATA_W(16), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ext_in_data  (ext_in_data),
        .ext_in_valid (ext_in_valid),
        .ext_in_ready (ext_in_ready),
        .in_rd        (in_rd),
        .inputPort    (inputPort),
        .in_empty     (in_empty),
        .out_wr       (out_wr),
        .out_wdata    (out_wdata),
        .outputPort   (outputPort),
        .out_valid    (out_valid),
        .irq_en       (irq_en),
        .interrupt    (interrupt),
        .clr_ovf      (clr_ovf),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ext_in_data  = 16'h0;
        ext_in_valid = 1'b0;
        in_rd        = 1'b0;
        out_wr       = 1'b0;
        out_wdata    = 16'h0;
        irq_en       = 1'b0;
        clr_ovf      = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        ext_in_data  = 16'hDEAD;
        ext_in_valid = 1'b1;
        in_rd        = 1'b1;
        out_wr       = 1'b1;
        out_wdata    = 16'hBEEF;
        irq_en       = 1'b1;
        clr_ovf      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        idle_inputs();
        total++; if (inputPort !== 16'h0) begin bad++; $display("FAIL reset_inputPort got=%h exp=%h", inputPort, 16'h0); end
        total++; if (in_empty !== 1'b1) begin bad++; $display("FAIL reset_in_empty got=%b exp=1", in_empty); end
        total++; if (ext_in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ext_in_ready); end
        total++; if (outputPort !== 16'h0) begin bad++; $display("FAIL reset_outputPort got=%h exp=%h", outputPort, 16'h0); end
        total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL reset_interrupt got=%b exp=0", interrupt); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_fifo_irq();
        logic [15:0] words [4];
        int irq_cnt;
        words[0] = 16'h0030; words[1] = 16'h0040;
        words[2] = 16'h0500; words[3] = 16'h0100;
        irq_cnt = 0;
        irq_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ext_in_data  = words[i];
            ext_in_valid = 1'b1;
            tick();
            if (interrupt === 1'b1) irq_cnt++;
            if (i == 0) begin
                total++; if (interrupt !== 1'b1 || inputPort !== 16'h0030 || in_empty !== 1'b0) begin
                    bad++; $display("FAIL irq_first_word irq=%b port=%h empty=%b exp irq=1 port=0030 empty=0", interrupt, inputPort, in_empty);
                end
            end
        end
        ext_in_valid = 1'b0;
        total++; if (ext_in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", ext_in_ready); end
        tick();
        if (interrupt === 1'b1) irq_cnt++;
        total++; if (irq_cnt != 1) begin bad++; $display("FAIL irq_pulse_count got=%0d exp=1", irq_cnt); end
        for (int i = 0; i < 4; i++) begin
            total++; if (inputPort !== words[i]) begin bad++; $display("FAIL fifo_order_%0d got=%h exp=%h", i, inputPort, words[i]); end
            in_rd = 1'b1;
            tick();
        end
        in_rd  = 1'b0;
        irq_en = 1'b0;
        total++; if (inputPort !== 16'h0 || in_empty !== 1'b1) begin
            bad++; $display("FAIL drained port=%h empty=%b exp port=0000 empty=1", inputPort, in_empty);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] words [4];
        words[0] = 16'h0011; words[1] = 16'h0022;
        words[2] = 16'h0033; words[3] = 16'h0044;
        for (int i = 0; i < 4; i++) begin
            ext_in_data  = words[i];
            ext_in_valid = 1'b1;
            tick();
        end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_before got=%b exp=0", overflow); end
        // Offer while full, also with a pop pending: the freed slot must not admit it.
        ext_in_data = 16'h07FF;
        in_rd       = 1'b1;
        tick();
        in_rd        = 1'b0;
        ext_in_valid = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        total++; if (ext_in_ready !== 1'b1) begin bad++; $display("FAIL ovf_ready_after_pop got=%b exp=1", ext_in_ready); end
        tick();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        for (int i = 1; i < 4; i++) begin
            total++; if (inputPort !== words[i]) begin bad++; $display("FAIL ovf_drain_%0d got=%h exp=%h", i, inputPort, words[i]); end
            in_rd = 1'b1;
            tick();
        end
        in_rd = 1'b0;
        total++; if (in_empty !== 1'b1 || inputPort !== 16'h0) begin
            bad++; $display("FAIL ovf_drained empty=%b port=%h exp empty=1 port=0000", in_empty, inputPort);
        end
        clr_ovf      = 1'b1;
        ext_in_valid = 1'b0;
        tick();
        clr_ovf = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_wrap();
        ext_in_data  = 16'h0001;
        ext_in_valid = 1'b1;
        tick();
        for (int k = 2; k <= 10; k++) begin
            total++; if (inputPort !== 16'(k - 1)) begin bad++; $display("FAIL wrap_head_%0d got=%h exp=%h", k, inputPort, 16'(k - 1)); end
            ext_in_data = 16'(k);
            in_rd       = 1'b1;
            tick();
            total++; if (in_empty !== 1'b0 || ext_in_ready !== 1'b1 || dut.r_count !== 3'd1) begin
                bad++; $display("FAIL wrap_count_%0d empty=%b ready=%b count=%0d exp 0 1 1", k, in_empty, ext_in_ready, dut.r_count);
            end
        end
        ext_in_valid = 1'b0;
        total++; if (inputPort !== 16'h000A) begin bad++; $display("FAIL wrap_last got=%h exp=000a", inputPort); end
        tick();
        in_rd = 1'b0;
        total++; if (in_empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", in_empty); end
    endtask

    task automatic test_empty_edge();
        irq_en       = 1'b1;
        ext_in_data  = 16'h1234;
        ext_in_valid = 1'b1;
        in_rd        = 1'b1;
        tick();
        ext_in_valid = 1'b0;
        in_rd        = 1'b0;
        total++; if (inputPort !== 16'h1234 || in_empty !== 1'b0 || dut.r_count !== 3'd1) begin
            bad++; $display("FAIL empty_push_pop port=%h empty=%b count=%0d exp 1234 0 1", inputPort, in_empty, dut.r_count);
        end
        total++; if (interrupt !== 1'b1) begin bad++; $display("FAIL empty_push_irq got=%b exp=1", interrupt); end
        in_rd = 1'b1;
        tick();
        tick();
        in_rd = 1'b0;
        total++; if (in_empty !== 1'b1 || dut.r_count !== 3'd0) begin
            bad++; $display("FAIL rd_on_empty empty=%b count=%0d exp 1 0", in_empty, dut.r_count);
        end
        irq_en       = 1'b0;
        ext_in_data  = 16'hABCD;
        ext_in_valid = 1'b1;
        tick();
        ext_in_valid = 1'b0;
        total++; if (inputPort !== 16'hABCD || interrupt !== 1'b0) begin
            bad++; $display("FAIL push_after_underflow port=%h irq=%b exp abcd 0", inputPort, interrupt);
        end
        in_rd = 1'b1;
        tick();
        in_rd = 1'b0;
    endtask

    task automatic test_output();
        out_wr    = 1'b1;
        out_wdata = 16'hF320;
        tick();
        total++; if (outputPort !== 16'hF320 || out_valid !== 1'b1) begin
            bad++; $display("FAIL out_first port=%h valid=%b exp f320 1", outputPort, out_valid);
        end
        out_wdata = 16'h0001;
        tick();
        total++; if (outputPort !== 16'h0001 || out_valid !== 1'b1) begin
            bad++; $display("FAIL out_second port=%h valid=%b exp 0001 1", outputPort, out_valid);
        end
        out_wr    = 1'b0;
        out_wdata = 16'h5555;
        tick();
        total++; if (outputPort !== 16'h0001 || out_valid !== 1'b0) begin
            bad++; $display("FAIL out_hold port=%h valid=%b exp 0001 0", outputPort, out_valid);
        end
        ext_in_data  = 16'h0777;
        ext_in_valid = 1'b1;
        tick();
        total++; if (in_empty !== 1'b0) begin bad++; $display("FAIL mid_push empty=%b exp=0", in_empty); end
        rst       = 1'b1;
        out_wr    = 1'b1;
        out_wdata = 16'h9999;
        tick();
        rst = 1'b0;
        idle_inputs();
        total++; if (outputPort !== 16'h0 || in_empty !== 1'b1 || inputPort !== 16'h0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL mid_reset port=%h empty=%b in=%h valid=%b exp 0000 1 0000 0", outputPort, in_empty, inputPort, out_valid);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_fifo_irq();
        test_overflow();
        test_wrap();
        test_empty_edge();
        test_output();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/io_port_bridge.md
# io_port_bridge

Buffers data from the external input device into the processor's `inputPort`, registers the processor's `outputPort` writes, and raises the processor's `interrupt` when input data becomes available. It sits between the board-level I/O pins and the `Processor` top level. The processor consumes input words with its IN instruction and produces output words with its OUT instruction.

## Interface
Parameters:
- `DATA_W`, 16: width of the I/O data words.
- `DEPTH`, 4: input FIFO depth; must be a power of 2 and at least 2.

Ports:
- `clk`, input, 1: the single clock; everything is updated on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `ext_in_data`, input, DATA_W: data word from the external device.
- `ext_in_valid`, input, 1: external device offers `ext_in_data` this cycle.
- `ext_in_ready`, output, 1: bridge can accept a word; equals `count != DEPTH`.
- `in_rd`, input, 1: processor IN-instruction strobe; pops the head word.
- `inputPort`, output, DATA_W: FIFO head word; 0 when the FIFO is empty.
- `in_empty`, output, 1: FIFO is empty.
- `out_wr`, input, 1: processor OUT-instruction strobe.
- `out_wdata`, input, DATA_W: word to be written to the output port.
- `outputPort`, output, DATA_W: registered output port value.
- `out_valid`, output, 1: one-cycle pulse marking a new `outputPort` value.
- `irq_en`, input, 1: enables interrupt generation.
- `interrupt`, output, 1: one-cycle data-available pulse to the processor.
- `clr_ovf`, input, 1: clears the `overflow` flag.
- `overflow`, output, 1: sticky flag; set when a word is offered while the FIFO is full.

## Operation
- **Reset.** While `rst` is high at a clock edge:
  - count, read pointer and write pointer go to 0.
  - `outputPort`, `out_valid`, `interrupt` and `overflow` go to 0.
  - Outputs therefore read `ext_in_ready`=1, `in_empty`=1, `inputPort`=0.
  - `rst` overrides every other input on the same edge. Reset mid-transfer discards all buffered words.
- **Push.** `push = ext_in_valid & ext_in_ready`. The word is written at the write pointer, and the pointer increments mod DEPTH.
- **Pop.** `pop = in_rd & !in_empty`. The read pointer increments mod DEPTH.
  - `in_rd` while empty is ignored: no pointer change and no error flag.
- **Count.** +1 on push only, −1 on pop only, unchanged on both or neither. Count range is 0..DEPTH.
  - Pointers wrap silently. Ordering is strict FIFO across the wrap.
- **Full.** `ext_in_ready` is derived from the registered count, so a simultaneous pop while full does not admit a push in that same cycle.
- **Empty with simultaneous in_rd and push.** The push is accepted and the pop is ignored.
- **Head output.** `inputPort` = `mem[rd_ptr]` when count≠0, else 0. It is combinational from registered state (first-word-fall-through).
- **Interrupt.** `interrupt <= irq_en & push & (count==0)`.
  - Only the empty→non-empty transition pulses.
  - Further pushes while the FIFO is non-empty do not re-pulse.
  - Dropping `irq_en` suppresses new pulses; it does not cancel a pulse already registered.
- **Overflow.** `overflow <= clr_ovf ? 0 : overflow | (ext_in_valid & !ext_in_ready)`.
  - `clr_ovf` wins over a simultaneous set.
  - The rejected word is dropped; the FIFO contents are unaffected.
- **Output port.**
  - On `out_wr`: `outputPort <= out_wdata` and `out_valid <= 1`.
  - Otherwise `outputPort` holds its value and `out_valid <= 0`.
  - Back-to-back writes update `outputPort` every cycle, with `out_valid` held high.

## Timing
- **Input latency.** A word pushed at edge N is visible on `inputPort` with `in_empty`=0 immediately after edge N (one cycle from offer to visible). `interrupt` is high in the same cycle as that first word becomes visible.
- **Pop latency.** `in_rd` sampled at edge N advances `inputPort` to the next word, or to 0, after edge N. The processor samples `inputPort` before asserting `in_rd`.
- **Throughput.** One push and one pop per cycle, sustained.
- **Output latency.** `outputPort` and `out_valid` change one edge after `out_wr`.
- **Flags.** `ext_in_ready`, `in_empty` and `inputPort` have no combinational path from `ext_in_valid` or `in_rd`.

## Test plan
- **Reset values.** Hold `rst` for 2 cycles with garbage on all inputs, then deassert → `inputPort`=0, `in_empty`=1, `ext_in_ready`=1, `outputPort`=0, `interrupt`=0, `overflow`=0.
- **FIFO order and interrupt.** `irq_en`=1; push 0x0030, 0x0040, 0x0500, 0x0100 on consecutive cycles →
  - `interrupt` pulses exactly once, alongside 0x0030.
  - `ext_in_ready`=0 after the 4th push.
  - Four `in_rd` pulses read 0x0030, 0x0040, 0x0500, 0x0100, then `inputPort`=0 and `in_empty`=1.
- **Overflow.** With the FIFO full, offer 0x07FF →
  - `overflow`=1 and stays high.
  - Draining the FIFO never yields 0x07FF.
  - `clr_ovf` pulse → `overflow`=0.
- **Wrap and simultaneous push/pop.** Stream 10 words (0x0001..0x000A) with push and pop every cycle after the first → count stays 1, and words are read in order across two pointer wraps.
- **Empty-edge cases.** `in_rd` plus a push of 0x1234 on an empty FIFO → 0x1234 is retained (count=1). A further `in_rd` on empty, after draining, leaves count at 0.
- **Output port.** `out_wr` with 0xF320, then 0x0001 back-to-back →
  - `outputPort` = 0xF320, then 0x0001.
  - `out_valid` is high for 2 cycles, then 0.
  - `outputPort` holds 0x0001 afterwards.
  - `rst` mid-stream clears `outputPort` to 0 and empties the FIFO.
